// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler and the units it drives:
// operation codes, operand/result widths and scheduler state encoding.
package alu_pkg;

  localparam int OP_W  = 4;
  localparam int OPD_W = 16;
  localparam int RES_W = 32;

  localparam logic [OP_W-1:0] DT_ADD   = 4'h0;
  localparam logic [OP_W-1:0] DT_MUL_S = 4'h1;
  localparam logic [OP_W-1:0] DT_MUL_U = 4'h2;
  localparam logic [OP_W-1:0] DT_DIV   = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/alu_op_sched_res_mux.sv
// Picks the done pulse and result of the unit addressed by the current
// opcode; every other unit's outputs are invisible to the scheduler.
module alu_op_sched_res_mux
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  dtype,
  input  logic             mul_s_done,
  input  logic [RES_W-1:0] mul_s_result,
  input  logic             mul_u_done,
  input  logic [RES_W-1:0] mul_u_result,
  input  logic             div_done,
  input  logic [RES_W-1:0] div_result,
  output logic             sel_done,
  output logic [RES_W-1:0] sel_result
);

  // Route only the selected unit's handshake; unknown codes never complete
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    case (dtype)
      DT_MUL_S: begin
        sel_done   = mul_s_done;
        sel_result = mul_s_result;
      end
      DT_MUL_U: begin
        sel_done   = mul_u_done;
        sel_result = mul_u_result;
      end
      DT_DIV: begin
        sel_done   = div_done;
        sel_result = div_result;
      end
      default: begin
        sel_done   = 1'b0;
        sel_result = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sched.sv
// One-at-a-time sequencer between the command parser and the ALU units.
// Additions and trivially failing requests are answered locally; multiplies
// and divides are issued with a single start pulse and awaited with a
// bounded timeout.
module alu_op_sched
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [OPD_W-1:0] req_a,
  input  logic [OPD_W-1:0] req_b,
  output logic             alu_start,
  output logic [OP_W-1:0]  alu_dtype,
  output logic [OPD_W-1:0] alu_m,
  output logic [OPD_W-1:0] alu_q,
  input  logic             mul_s_done,
  input  logic [RES_W-1:0] mul_s_result,
  input  logic             mul_u_done,
  input  logic [RES_W-1:0] mul_u_result,
  input  logic             div_done,
  input  logic [RES_W-1:0] div_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  sched_state_e     state;
  logic [TO_W-1:0]  to_cnt;
  logic             sel_done;
  logic [RES_W-1:0] sel_result;

  // 17-bit signed sum of the operands, sign-extended to the result width
  function automatic logic [RES_W-1:0] add_sext(input logic signed [OPD_W-1:0] a,
                                                input logic signed [OPD_W-1:0] b);
    logic signed [OPD_W:0] ae;
    logic signed [OPD_W:0] be;
    logic signed [OPD_W:0] s;
    ae = a;
    be = b;
    s  = ae + be;
    return {{(RES_W-OPD_W-1){s[OPD_W]}}, s};
  endfunction

  // Requests that can never produce a unit result are rejected in IDLE
  function automatic logic is_reject(input logic [OP_W-1:0]  op,
                                     input logic [OPD_W-1:0] b);
    return (op > DT_DIV) || ((op == DT_DIV) && (b == '0));
  endfunction

  alu_op_sched_res_mux u_res_mux (
    .dtype        (alu_dtype),
    .mul_s_done   (mul_s_done),
    .mul_s_result (mul_s_result),
    .mul_u_done   (mul_u_done),
    .mul_u_result (mul_u_result),
    .div_done     (div_done),
    .div_result   (div_result),
    .sel_done     (sel_done),
    .sel_result   (sel_result)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // Scheduler FSM with registered unit-side and response-side outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      alu_start <= 1'b0;
      alu_dtype <= '0;
      alu_m     <= '0;
      alu_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_dtype <= req_op;
            alu_m     <= req_a;
            alu_q     <= req_b;
            if (req_op == DT_ADD) begin
              res_data  <= add_sext(req_a, req_b);
              res_err   <= 1'b0;
              res_valid <= 1'b1;
              state     <= ST_RESP;
            end else if (is_reject(req_op, req_b)) begin
              res_data  <= '0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              // start rises with the ISSUE state so it lasts exactly one cycle
              alu_start <= 1'b1;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          to_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // done is tested first so it wins over a coincident timeout
          if (sel_done) begin
            res_data  <= sel_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
